// File: rtl/aes_key_expand_128.sv
// AES-128 key expansion: derives round keys 0..10 two cycles per round through
// a shared external 32-bit S-box and serves any stored round key combinationally.
module aes_key_expand_128 (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  typedef enum logic [1:0] {IDLE, ROT, SUB} state_e;

  state_e       state_q, state_d;
  logic [127:0] km_q [11];
  logic [127:0] km_d [11];
  logic [127:0] prev_q, prev_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rc_q, rc_d;
  logic         ready_q, ready_d;

  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_next;

  // RotWord of the last key word; held constant across ROT and SUB so a
  // registered S-box has its result ready by SUB.
  assign sboxw = {prev_q[23:0], prev_q[31:24]};
  assign ready = ready_q;

  assign t_word    = new_sboxw ^ {rcon_q, 24'h0};
  assign n0        = prev_q[127:96] ^ t_word;
  assign n1        = prev_q[95:64]  ^ n0;
  assign n2        = prev_q[63:32]  ^ n1;
  assign n3        = prev_q[31:0]   ^ n2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    round_key = '0;
    for (int i = 0; i < 11; i++) begin
      if (round == 4'(i)) round_key = km_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    rcon_d  = rcon_q;
    rc_d    = rc_q;
    ready_d = ready_q;
    for (int i = 0; i < 11; i++) km_d[i] = km_q[i];

    unique case (state_q)
      IDLE: begin
        if (init) begin
          km_d[0] = key;
          prev_d  = key;
          rcon_d  = 8'h01;
          rc_d    = 4'd1;
          ready_d = 1'b0;
          state_d = ROT;
        end
      end
      ROT: state_d = SUB;
      SUB: begin
        for (int i = 1; i < 11; i++) begin
          if (rc_q == 4'(i)) km_d[i] = {n0, n1, n2, n3};
        end
        prev_d = {n0, n1, n2, n3};
        rcon_d = rcon_next;
        rc_d   = rc_q + 4'd1;
        if (rc_q == 4'd10) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ROT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      rcon_q  <= 8'h01;
      rc_q    <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < 11; i++) km_q[i] <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      rcon_q  <= rcon_d;
      rc_q    <= rc_d;
      ready_q <= ready_d;
      for (int i = 0; i < 11; i++) km_q[i] <= km_d[i];
    end
  end

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Scoreboard bench for aes_key_expand_128: a word-level FIPS-197 key schedule
// model predicts all round keys; a monitor sweeps `round` each time ready rises.
module tb_aes_key_expand_128;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         init = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   round = 4'd0;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef logic [10:0][127:0] keys_t;
  typedef struct {
    keys_t        keys;
    int           e0;
    bit           kat;
    logic [127:0] kat1;
    logic [127:0] kat10;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_busy = 1'b0;
  bit         use_reg = 1'b0;
  logic [7:0] sbox_tab [256];
  logic [31:0] sbox_reg;

  aes_key_expand_128 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .key       (key_in),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // External S-box, switchable between combinational and 1-cycle registered.
  always @(posedge clk) sbox_reg <= sub_word(sboxw);
  assign new_sboxw = use_reg ? sbox_reg : sub_word(sboxw);

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic keys_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    keys_t       r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        w[i] = w[i-4] ^ sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else begin
        w[i] = w[i-4] ^ w[i-1];
      end
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Issue an init pulse and queue the predicted schedule; ready must be low after the edge.
  task automatic applyStimulus(input logic [127:0] k, input bit kat,
                               input logic [127:0] k1, input logic [127:0] k10);
    exp_t e;
    @(negedge clk);
    key_in = k;
    init   = 1'b1;
    e.keys  = expand(k);
    e.e0    = cyc + 1;
    e.kat   = kat;
    e.kat1  = k1;
    e.kat10 = k10;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    init = 1'b0;
    checkOutput("ready_low_after_init", {127'h0, ready}, 128'h0);
  endtask

  task automatic waitDone();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #2;
      if (ready && !mon_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL expansion_timeout: ready=%0b pending=%0d", ready, exp_q.size());
    end
  endtask

  // Monitor: on each rising edge of ready, pop the prediction and sweep every round index.
  initial begin
    bit ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready && !ready_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: no expansion pending at cycle %0d", cyc);
        end else begin
          exp_t e;
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          checkOutput("latency", 128'(cyc - e.e0), 128'd20);
          for (int r = 0; r < 16; r++) begin
            round = 4'(r);
            #1;
            checkOutput($sformatf("round%0d", r), round_key, (r <= 10) ? e.keys[r] : 128'h0);
            if (e.kat && r == 1)  checkOutput("kat_round1", round_key, e.kat1);
            if (e.kat && r == 10) checkOutput("kat_round10", round_key, e.kat10);
          end
          round = 4'd1;
          mon_busy = 1'b0;
        end
      end
      ready_prev = ready;
    end
  end

  initial begin
    logic [127:0] rk;
    build_sbox();
    round = 4'd1;
    #12;
    checkOutput("reset_ready", {127'h0, ready}, 128'h0);
    checkOutput("reset_round_key", round_key, 128'h0);
    checkOutput("reset_sboxw", {96'h0, sboxw}, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] FIPS and zero keys, combinational S-box");
    applyStimulus(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);
    waitDone();
    applyStimulus(128'h0, 1'b1, ZERO_R1, ZERO_R10);
    waitDone();

    $display("[TB] FIPS and zero keys, registered S-box");
    use_reg = 1'b1;
    applyStimulus(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);
    waitDone();
    applyStimulus(128'h0, 1'b1, ZERO_R1, ZERO_R10);
    waitDone();
    use_reg = 1'b0;

    $display("[TB] init during expansion is ignored");
    applyStimulus(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);
    repeat (6) @(negedge clk);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    init   = 1'b1;
    @(negedge clk);
    init   = 1'b0;
    waitDone();

    $display("[TB] asynchronous reset mid-expansion");
    rk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(rk, 1'b0, 128'h0, 128'h0);
    repeat (8) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midreset_ready", {127'h0, ready}, 128'h0);
    checkOutput("midreset_round_key", round_key, 128'h0);
    checkOutput("midreset_sboxw", {96'h0, sboxw}, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);
    waitDone();

    $display("[TB] back-to-back restart while ready");
    applyStimulus(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);
    waitDone();

    $display("[TB] random keys");
    for (int n = 0; n < 6; n++) begin
      use_reg = 1'($urandom_range(0, 1));
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0, 128'h0);
      waitDone();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
